// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
// pred_entry_t carries everything needed to judge one prediction later:
// the fall-through PC, the predicted target and the predicted direction.
package bru_pkg;

   localparam int BRU_XLEN    = 32;
   localparam int BRU_PC_STEP = 4;

   typedef struct packed {
      logic [BRU_XLEN-1:0] pc_next;
      logic [BRU_XLEN-1:0] target;
      logic                taken;
   } pred_entry_t;

   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } bru_state_t;

endpackage

// File: rtl/bru_queue.sv
// Circular buffer of outstanding predictions, oldest at the head.
// Pointers wrap modulo DEPTH; count never exceeds DEPTH because push is
// ignored when full and pop is ignored when empty. clear empties the
// queue and overrides any push or pop in the same cycle.
module bru_queue
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  pred_entry_t              push_entry,
   input  logic                     pop,
   input  logic                     clear,
   output pred_entry_t              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   pred_entry_t          mem_q [DEPTH];
   pred_entry_t          mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 push_eff;
   logic                 pop_eff;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Next pointers, count and storage contents for push/pop/clear
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_eff = push && !full;
      pop_eff  = pop && !empty;
      if (clear) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push_eff) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push_eff && !pop_eff) begin
            count_d = count_q + 1'b1;
         end else if (pop_eff && !push_eff) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Queue state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues predictions from fetch/decode, checks
// them in order against execute outcomes, and on a mispredict flushes the
// queue and issues a one-cycle redirect to the correct PC.
// Optional feature macro: BRU_PERF_COUNTERS_EN adds perf_branches and
// perf_mispredicts saturating counters.
module branch_resolution_unit
   import bru_pkg::*;
#(
   parameter int XLEN  = BRU_XLEN,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   output logic                     pred_ready,
   input  logic [XLEN-1:0]          pred_pc_next,
   input  logic [XLEN-1:0]          pred_target,
   input  logic                     pred_taken,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic [XLEN-1:0]          res_target,
   output logic                     redirect_valid,
   output logic [XLEN-1:0]          redirect_pc,
   output logic                     flush,
   output logic                     res_error,
   output logic [$clog2(DEPTH):0]   count
`ifdef BRU_PERF_COUNTERS_EN
   ,
   output logic [31:0]              perf_branches,
   output logic [31:0]              perf_mispredicts
`endif
);

   bru_state_t         state_q, state_d;
   logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
   logic               res_error_q, res_error_d;
   pred_entry_t        head;
   pred_entry_t        push_entry;
   logic               q_full;
   logic               q_empty;
   logic               push;
   logic               accepted;
   logic               mispredict;

   assign push_entry = '{pc_next: pred_pc_next, target: pred_target, taken: pred_taken};

   bru_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (accepted),
      .clear      (mispredict),
      .head       (head),
      .count      (count),
      .full       (q_full),
      .empty      (q_empty)
   );

   // FSM next state, handshake and mispredict detection; squashed enqueues are dropped
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      pred_ready    = 1'b0;
      accepted      = 1'b0;
      mispredict    = 1'b0;
      res_error_d   = 1'b0;
      unique case (state_q)
         RUN: begin
            pred_ready  = !q_full && !reset;
            accepted    = res_valid && !q_empty;
            res_error_d = res_valid && q_empty;
            mispredict  = accepted &&
                          ((res_taken != head.taken) ||
                           (res_taken && (res_target != head.target)));
            if (mispredict) begin
               state_d       = REDIRECT;
               redirect_pc_d = res_taken ? res_target : head.pc_next;
            end
         end
         REDIRECT: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      push = pred_valid && pred_ready && !mispredict;
   end

   // Control state, redirect target and error pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         redirect_pc_q <= '0;
         res_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         res_error_q   <= res_error_d;
      end
   end

   assign redirect_valid = (state_q == REDIRECT);
   assign flush          = (state_q == REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign res_error      = res_error_q;

`ifdef BRU_PERF_COUNTERS_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

   // Saturating event counts for resolves and mispredicts
   always_comb begin
      perf_branches_d    = perf_branches_q;
      perf_mispredicts_d = perf_mispredicts_q;
      if (accepted && (perf_branches_q != 32'hFFFF_FFFF)) begin
         perf_branches_d = perf_branches_q + 32'd1;
      end
      if (mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
         perf_mispredicts_d = perf_mispredicts_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
